// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite definitions: transfer/response encodings and the
// default-slave state type used by the slave multiplexer.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ahb_ds_states;

endpackage

// File: rtl/ahb3lite_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with a two-cycle
// ERROR response and everything else with a zero-wait OKAY.
module ahb3lite_default_slave
  import ahb3lite_pkg::*;
#(
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  ahb_ds_states r_state;
  ahb_ds_states w_next;
  logic         w_req;

  assign w_req = HSEL & HREADY &
                 ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= DS_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DS_IDLE: if (w_req) w_next = DS_ERR1;
      DS_ERR1: w_next = DS_ERR2;
      DS_ERR2: w_next = w_req ? DS_ERR1 : DS_IDLE;
      default: w_next = DS_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (r_state)
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      DS_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb3lite_slave_mux.sv
// Single-master AHB3-Lite address decoder and response multiplexer with a
// built-in default slave for unmapped addresses.
module ahb3lite_slave_mux
  import ahb3lite_pkg::*;
#(
  parameter int                             SLAVES     = 4,
  parameter int                             HADDR_SIZE = 32,
  parameter int                             HDATA_SIZE = 32,
  parameter logic [SLAVES*HADDR_SIZE-1:0]   SLAVE_BASE = '0,
  parameter logic [SLAVES*HADDR_SIZE-1:0]   SLAVE_MASK = '0
) (
  input  logic                         HRESETn,
  input  logic                         HCLK,
  input  logic [HADDR_SIZE-1:0]        HADDR,
  input  logic [1:0]                   HTRANS,
  output logic                         HREADY,
  output logic [HDATA_SIZE-1:0]        HRDATA,
  output logic                         HRESP,
  output logic [SLAVES-1:0]            S_HSEL,
  input  logic [SLAVES*HDATA_SIZE-1:0] S_HRDATA,
  input  logic [SLAVES-1:0]            S_HREADYOUT,
  input  logic [SLAVES-1:0]            S_HRESP
);

  logic [SLAVES-1:0]     w_hsel;
  logic                  w_nomatch;
  logic [SLAVES:0]       r_dsel;
  logic                  w_ds_hreadyout;
  logic                  w_ds_hresp;
  logic [HDATA_SIZE-1:0] w_ds_hrdata;

  // Lowest matching index wins, so overlapping windows still give one-hot.
  always_comb begin
    logic [HADDR_SIZE-1:0] v_base, v_mask;
    logic                  v_found;
    w_hsel  = '0;
    v_found = 1'b0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      v_base = SLAVE_BASE[i*HADDR_SIZE +: HADDR_SIZE];
      v_mask = SLAVE_MASK[i*HADDR_SIZE +: HADDR_SIZE];
      if (!v_found && (v_mask != '0) && ((HADDR & v_mask) == (v_base & v_mask))) begin
        w_hsel[i] = 1'b1;
        v_found   = 1'b1;
      end
    end
  end

  assign w_nomatch = (w_hsel == '0);
  assign S_HSEL    = w_hsel;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    r_dsel <= {1'b1, {SLAVES{1'b0}}};
    else if (HREADY) r_dsel <= {w_nomatch, w_hsel};
  end

  ahb3lite_default_slave #(
    .HDATA_SIZE (HDATA_SIZE)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (w_nomatch),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (w_ds_hreadyout),
    .HRESP     (w_ds_hresp),
    .HRDATA    (w_ds_hrdata)
  );

  always_comb begin
    HREADY = w_ds_hreadyout;
    HRESP  = w_ds_hresp;
    HRDATA = w_ds_hrdata;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (r_dsel[i]) begin
        HREADY = S_HREADYOUT[i];
        HRESP  = S_HRESP[i];
        HRDATA = S_HRDATA[i*HDATA_SIZE +: HDATA_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_slave_mux.sv
// Randomised and directed bench for ahb3lite_slave_mux, checked against a
// transfer-level model of ownership and the two-cycle error response.
module tb_ahb3lite_slave_mux;

  localparam int NS = 4;
  localparam logic [NS*32-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'h0000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HREADY;
  logic [31:0]     HRDATA;
  logic            HRESP;
  logic [NS-1:0]   S_HSEL;
  logic [NS*32-1:0] S_HRDATA;
  logic [NS-1:0]   S_HREADYOUT;
  logic [NS-1:0]   S_HRESP;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner of the data phase (NS = default slave) and error cycle (0 none, 1 first, 2 second)
  int m_owner = NS;
  int m_err   = 0;
  logic [31:0] m_base [NS];
  logic [31:0] m_mask [NS];

  ahb3lite_slave_mux #(
    .SLAVES     (NS),
    .HADDR_SIZE (32),
    .HDATA_SIZE (32),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK)
  ) dut (
    .HRESETn     (HRESETn),
    .HCLK        (HCLK),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .S_HSEL      (S_HSEL),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP)
  );

  always #5 HCLK = ~HCLK;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (m_mask[i] != 0 && (a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return NS;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_rdata;
    logic        e_ready, e_resp;
    logic [NS-1:0] e_sel;
    int d;
    d = decode(HADDR);
    e_sel = '0;
    if (d < NS) e_sel[d] = 1'b1;
    if (m_owner < NS) begin
      e_ready = S_HREADYOUT[m_owner];
      e_resp  = S_HRESP[m_owner];
      e_rdata = S_HRDATA[m_owner*32 +: 32];
    end else begin
      e_ready = (m_err != 1);
      e_resp  = (m_err != 0);
      e_rdata = 32'h0;
    end
    chk("HSEL",   32'(S_HSEL), 32'(e_sel));
    chk("HREADY", 32'(HREADY), 32'(e_ready));
    chk("HRESP",  32'(HRESP),  32'(e_resp));
    chk("HRDATA", HRDATA,      e_rdata);
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_edge();
    logic ready;
    ready = (m_owner < NS) ? S_HREADYOUT[m_owner] : (m_err != 1);
    if (!HRESETn) begin
      m_owner = NS;
      m_err   = 0;
    end else if (m_err == 1) begin
      m_err = 2;
    end else if (ready) begin
      m_owner = decode(HADDR);
      m_err   = (m_owner == NS && HTRANS[1]) ? 1 : 0;
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [NS-1:0] rdy,
                      input logic [NS-1:0] rsp, input logic [NS*32-1:0] data);
    @(negedge HCLK);
    HADDR       = a;
    HTRANS      = t;
    S_HREADYOUT = rdy;
    S_HRESP     = rsp;
    S_HRDATA    = data;
    #1;
    check_outputs();
    model_edge();
  endtask

  localparam logic [NS*32-1:0] DATA = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0BAD_BEEF};

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_base[i] = BASE[i*32 +: 32];
      m_mask[i] = MASK[i*32 +: 32];
    end
    HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00;
    S_HREADYOUT = '1; S_HRESP = '0; S_HRDATA = DATA;

    // Reset: HSEL still follows HADDR, response is idle OKAY
    step(32'h1000_0004, 2'b10, 4'hF, 4'h0, DATA);
    step(32'h2000_0000, 2'b10, 4'hF, 4'h0, DATA);
    @(posedge HCLK); #2 HRESETn = 1'b1;

    // Mapped NONSEQ to slave1 (also overlapped by slave2, slave1 wins)
    step(32'h1000_0004, 2'b10, 4'hF, 4'h0, DATA);
    chk("hsel_s1", 32'(S_HSEL), 32'h2);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("rdata_s1", HRDATA, 32'hCAFE_F00D);
    chk("resp_s1", 32'(HRESP), 32'h0);

    // Back-to-back slave0 then slave1
    step(32'h0000_0000, 2'b10, 4'hF, 4'h0, DATA);
    step(32'h1000_0000, 2'b10, 4'hF, 4'h0, DATA);
    chk("b2b_s0", HRDATA, 32'h0BAD_BEEF);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("b2b_s1", HRDATA, 32'hCAFE_F00D);

    // Slave1 stalls 3 cycles while the next address targets slave0
    step(32'h1000_0008, 2'b10, 4'hF, 4'h0, DATA);
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0010, 2'b10, 4'b1101, 4'h0, DATA);
      chk("stall_rdy", 32'(HREADY), 32'h0);
    end
    step(32'h0000_0010, 2'b10, 4'hF, 4'h0, DATA);
    chk("stall_rel", 32'(HREADY), 32'h1);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("after_stall", HRDATA, 32'h0BAD_BEEF);

    // Unmapped NONSEQ: two-cycle ERROR then back to idle OKAY
    step(32'h2000_0000, 2'b10, 4'hF, 4'h0, DATA);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("err1", {HREADY, HRESP}, 32'h1);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("err2", {HREADY, HRESP}, 32'h3);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    chk("err_done", {HREADY, HRESP}, 32'h2);

    // Unmapped IDLE is a zero-wait OKAY
    step(32'h2000_0000, 2'b00, 4'hF, 4'h0, DATA);
    step(32'h2000_0000, 2'b01, 4'hF, 4'h0, DATA);
    chk("idle_unmapped", {HREADY, HRESP}, 32'h2);

    // Reset asserted during the first error cycle
    step(32'h3000_0000, 2'b11, 4'hF, 4'h0, DATA);
    @(negedge HCLK);
    HADDR = 32'h0; HTRANS = 2'b00;
    #1 chk("rst_err1", {HREADY, HRESP}, 32'h1);
    HRESETn = 1'b0;
    m_owner = NS; m_err = 0;
    #1 check_outputs();
    chk("rst_mid", {HREADY, HRESP}, 32'h2);
    @(posedge HCLK); #2 HRESETn = 1'b1;
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);
    step(32'h0000_0000, 2'b00, 4'hF, 4'h0, DATA);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [NS-1:0] rdy, rsp;
      logic [NS*32-1:0] d;
      case ($urandom_range(0, 4))
        0: a = {4'h0, 28'($urandom)};
        1: a = {4'h1, 28'($urandom)};
        2: a = {16'h1000, 16'($urandom)};
        3: a = {4'h2, 28'($urandom)};
        default: a = $urandom;
      endcase
      for (int i = 0; i < NS; i++) begin
        rdy[i] = ($urandom_range(0, 3) != 0);
        rsp[i] = ($urandom_range(0, 7) == 0);
        d[i*32 +: 32] = $urandom;
      end
      step(a, 2'($urandom_range(0, 3)), rdy, rsp, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb3lite_slave_mux.md
# ahb3lite_slave_mux

Single-master AHB3-Lite address decoder and response multiplexer. It sits between the CPU-side AHB3-Lite master port and up to SLAVES AHB3-Lite slaves, including the APB bridges. It generates per-slave HSEL during the address phase and tracks which slave owns the data phase. It routes that slave's HRDATA/HREADYOUT/HRESP back to the master. A built-in default slave answers accesses to unmapped addresses.

## Interface
- SLAVES, 4: number of attached slaves (1..16)
- HADDR_SIZE, 32: address width
- HDATA_SIZE, 32: data width
- SLAVE_BASE, all 0: packed SLAVES*HADDR_SIZE vector. Slice i is the base address of slave i.
- SLAVE_MASK, all 0: packed SLAVES*HADDR_SIZE vector. Slice i is the decode mask of slave i; a mask of 0 disables slave i.

Ports:
- HRESETn  in  1  asynchronous, active-low reset
- HCLK  in  1  clock
- HADDR  in  HADDR_SIZE  master address
- HTRANS  in  2  master transfer type
- HREADY  out  1  muxed ready; drives the master and is broadcast to every slave HREADY input
- HRDATA  out  HDATA_SIZE  muxed read data
- HRESP  out  1  muxed response
- S_HSEL  out  SLAVES  one-hot slave select (address phase)
- S_HRDATA  in  SLAVES*HDATA_SIZE  slave read data, slice i
- S_HREADYOUT  in  SLAVES  slave ready
- S_HRESP  in  SLAVES  slave response

HWDATA, HWRITE, HSIZE, HBURST, HPROT and HMASTLOCK are wired directly from the master to the slaves. They do not pass through this block.

## Operation
- Match rule: slave i matches when (HADDR & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i]) and SLAVE_MASK[i] != 0.
- Overlapping windows: the lowest matching index wins, so S_HSEL is strictly one-hot or zero.
- S_HSEL is combinational from HADDR and is driven regardless of HTRANS. Slaves qualify it with HTRANS and HREADY.
- No match: the default slave is selected internally.
- Data-phase owner register `dsel`:
  - SLAVES+1 bits, one-hot; bit SLAVES is the default slave.
  - Loads the address-phase selection on every HCLK edge where HREADY=1.
  - Holds while HREADY=0.
- Output mux: when `dsel` points at slave i, HREADY, HRDATA and HRESP equal S_HREADYOUT[i], S_HRDATA slice i and S_HRESP[i].
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 when HREADY=1, no slave matches and HTRANS is NONSEQ or SEQ. Otherwise it stays in DS_IDLE.
  - DS_ERR1: drives HREADYOUT=0, HRESP=ERROR. Always goes to DS_ERR2 on the next cycle.
  - DS_ERR2: drives HREADYOUT=1, HRESP=ERROR. It goes to DS_ERR1 if a new unmapped NONSEQ/SEQ is sampled (HREADY is 1 here), otherwise to DS_IDLE.
  - DS_IDLE: drives HREADYOUT=1, HRESP=OKAY.
  - Default-slave HRDATA is always 0.
- Unmapped IDLE/BUSY: zero-wait OKAY.

## Timing
- Reset values:
  - `dsel` = default slave, FSM = DS_IDLE.
  - Outputs therefore read HREADY=1, HRESP=OKAY, HRDATA=0.
  - S_HSEL follows HADDR combinationally, even during reset.
- Latency: HSEL is combinational in the address phase. The response mux switches on the clock edge that ends the address phase (HREADY=1).
- Error response is exactly 2 cycles: the first with HREADY=0 and HRESP=1, the second with HREADY=1 and HRESP=1.
- Back-to-back transfers to different slaves: `dsel` switches in the same edge, with no bubble cycle.
- Stalled slave (S_HREADYOUT=0): `dsel` and the FSM hold. The address-phase S_HSEL may change, but the new address is not sampled.
- Reset asserted mid-transfer or mid-error: immediate return to reset values. No pending error is replayed.
- No combinational path from S_HREADYOUT to S_HSEL.

## Structure
- Add the following to the shared ahb3lite package:
  - HTRANS_*/HRESP_* constants (already present).
  - Typedef `ahb_ds_states` {DS_IDLE, DS_ERR1, DS_ERR2}.
- One sub-module: `ahb3lite_default_slave`, containing the FSM. Its ports are HCLK, HRESETn, HSEL, HTRANS, HREADY, HREADYOUT, HRESP and HRDATA.
- Top level contains the decode loop, the `dsel` register and the response mux.

## Test plan
- SLAVES=2, slave0 base 0x0000_0000 mask 0xF000_0000, slave1 base 0x1000_0000 mask 0xF000_0000:
  - NONSEQ to 0x1000_0004 → S_HSEL=2'b10.
  - Next cycle HRDATA = S_HRDATA slice 1 (0xCAFE_F00D), HRESP=OKAY.
- Back-to-back NONSEQ 0x0000_0000 then 0x1000_0000, both slaves zero-wait → HRDATA sources slave0 then slave1 on consecutive cycles, with no wait state.
- Slave1 holds S_HREADYOUT=0 for 3 cycles → HREADY=0 for 3 cycles. A following access to slave0 is not switched until slave1 releases.
- NONSEQ to unmapped 0x2000_0000 → HREADY/HRESP = 0/1, then 1/1. The FSM then returns to DS_IDLE and HRDATA=0.
- IDLE transfer to 0x2000_0000 → HREADY=1, HRESP=OKAY, no error.
- HRESETn pulsed low during DS_ERR1 → next cycle HREADY=1, HRESP=OKAY, `dsel` = default slave.
